// File: rtl/stopwatch_pkg.sv
// Shared types, limits and helpers for the stopwatch time datapath.
// BCD pairs are kept as {tens, ones} so one increment helper serves both fields.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  localparam int DEF_DIV_RUN   = 100_000_000;
  localparam int DEF_DIV_ADJ   = 50_000_000;
  localparam int DEF_DIV_BLINK = 25_000_000;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 99;

  localparam logic [3:0] SEC_TENS_MAX = 4'(SEC_MAX / 10);
  localparam logic [3:0] MIN_TENS_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] ONES_MAX     = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic logic bcd_at_max(bcd_t v, logic [3:0] tens_max);
    return (v.tens == tens_max) && (v.ones == ONES_MAX);
  endfunction

  // Increment with wrap to 00 after tens_max/9; the carry is left to the caller.
  function automatic bcd_t bcd_inc(bcd_t v, logic [3:0] tens_max);
    bcd_t r;
    r = v;
    if (v.ones == ONES_MAX) begin
      r.ones = 4'd0;
      r.tens = (v.tens == tens_max) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick on the terminal count of 0..DIV-1.
// Counts only while en, holds otherwise; clr is synchronous and wins over en.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM and MM:SS BCD time counters with run, adjust and blink prescalers.
// Every output comes straight from a flop; blanking is precomputed against next state/phase.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV_RUN   = DEF_DIV_RUN,
  parameter int DIV_ADJ   = DEF_DIV_ADJ,
  parameter int DIV_BLINK = DEF_DIV_BLINK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause_vld,
  input  logic       reset_vld,
  input  logic       adj_vld,
  input  logic       adj_sel,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       blank_sec,
  output logic       blank_min,
  output logic [1:0] state
);

  state_t state_q, state_d;
  bcd_t   sec_q, sec_d, min_q, min_d;
  logic   phase_q, phase_d;
  logic   blank_sec_q, blank_sec_d, blank_min_q, blank_min_d;
  logic   run_tick, adj_tick, blink_tick;
  logic   in_run, in_adj, to_adj;

  assign in_run = (state_q == ST_RUN);
  assign in_adj = (state_q == ST_ADJ);

  // Run prescaler is parked at 0 throughout ADJ so the first run tick after leaving is a full period.
  tick_gen #(.DIV(DIV_RUN)) u_run_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (reset_vld | in_adj),
    .en   (in_run),
    .tick (run_tick)
  );

  tick_gen #(.DIV(DIV_ADJ)) u_adj_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (~in_adj),
    .en   (in_adj),
    .tick (adj_tick)
  );

  tick_gen #(.DIV(DIV_BLINK)) u_blink_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (~in_adj),
    .en   (in_adj),
    .tick (blink_tick)
  );

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;

    if (adj_vld)        state_d = ST_ADJ;
    else if (pause_vld) state_d = ST_PAUSE;
    else                state_d = ST_RUN;

    if (reset_vld) begin
      sec_d = '0;
      min_d = '0;
    end else if (run_tick) begin
      sec_d = bcd_inc(sec_q, SEC_TENS_MAX);
      if (bcd_at_max(sec_q, SEC_TENS_MAX)) min_d = bcd_inc(min_q, MIN_TENS_MAX);
    end else if (adj_tick) begin
      if (adj_sel) sec_d = bcd_inc(sec_q, SEC_TENS_MAX);
      else         min_d = bcd_inc(min_q, MIN_TENS_MAX);
    end

    to_adj      = (state_d == ST_ADJ);
    phase_d     = (in_adj && to_adj) ? (phase_q ^ blink_tick) : 1'b1;
    blank_sec_d = to_adj &  adj_sel & ~phase_d;
    blank_min_d = to_adj & ~adj_sel & ~phase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sec_q       <= '0;
      min_q       <= '0;
      phase_q     <= 1'b1;
      blank_sec_q <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      phase_q     <= phase_d;
      blank_sec_q <= blank_sec_d;
      blank_min_q <= blank_min_d;
    end
  end

  assign sec_ones  = sec_q.ones;
  assign sec_tens  = sec_q.tens;
  assign min_ones  = min_q.ones;
  assign min_tens  = min_q.tens;
  assign blank_sec = blank_sec_q;
  assign blank_min = blank_min_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: integer-time model compared every cycle,
// directed scenarios pinned with literal expectations, then a randomized mode soak.
module tb_stopwatch_ctrl;

  localparam int DIV_RUN   = 10;
  localparam int DIV_ADJ   = 4;
  localparam int DIV_BLINK = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause_vld = 1'b0, reset_vld = 1'b0, adj_vld = 1'b0, adj_sel = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       blank_sec, blank_min;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_ctrl #(
    .DIV_RUN  (DIV_RUN),
    .DIV_ADJ  (DIV_ADJ),
    .DIV_BLINK(DIV_BLINK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pause_vld(pause_vld),
    .reset_vld(reset_vld),
    .adj_vld  (adj_vld),
    .adj_sel  (adj_sel),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .blank_sec(blank_sec),
    .blank_min(blank_min),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [19:0] actual, input logic [19:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Behavioural model: mode 0/1/2 = run/pause/adjust, time as plain integers.
  int m_mode = 0, m_run = 0, m_adj = 0, m_blink = 0, m_sec = 0, m_min = 0;
  int m_next;
  bit m_phase = 1'b1, m_sel = 1'b0;
  bit m_rt, m_at, m_bt;
  logic [19:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_adj = 0; m_blink = 0;
      m_sec = 0; m_min = 0; m_phase = 1'b1; m_sel = 1'b0;
    end else begin
      m_next = adj_vld ? 2 : (pause_vld ? 1 : 0);
      m_rt = (m_mode == 0) && !reset_vld && (m_run == DIV_RUN - 1);
      m_at = (m_mode == 2) && (m_adj == DIV_ADJ - 1);
      m_bt = (m_mode == 2) && (m_blink == DIV_BLINK - 1);

      if (reset_vld || m_mode == 2) m_run = 0;
      else if (m_mode == 0)         m_run = (m_run + 1) % DIV_RUN;
      m_adj   = (m_mode == 2) ? (m_adj + 1) % DIV_ADJ : 0;
      m_blink = (m_mode == 2) ? (m_blink + 1) % DIV_BLINK : 0;

      if (reset_vld) begin
        m_sec = 0; m_min = 0;
      end else if (m_rt) begin
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min = (m_min + 1) % 100;
        end
      end else if (m_at) begin
        if (adj_sel) m_sec = (m_sec + 1) % 60;
        else         m_min = (m_min + 1) % 100;
      end

      m_phase = (m_mode == 2 && m_next == 2) ? (m_phase ^ m_bt) : 1'b1;
      m_sel   = adj_sel;
      m_mode  = m_next;
    end
    #1;
    m_exp = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10), 2'(m_mode),
             (m_mode == 2) && m_sel && !m_phase, (m_mode == 2) && !m_sel && !m_phase};
    check("model", {digits(), state, blank_sec, blank_min}, m_exp);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {digits(), state, blank_sec, blank_min}, 20'h00000);
    rst_n = 1'b1;

    // 600 run ticks from reset
    repeat (600 * DIV_RUN) @(negedge clk);
    check("run_600", {4'h0, digits()}, 20'h01000);

    // preload 99:59 through adjust mode, then exit and wrap on one run tick
    adj_vld = 1'b1; adj_sel = 1'b0;
    repeat (1 + 89 * DIV_ADJ) @(negedge clk);
    adj_sel = 1'b1;
    repeat (59 * DIV_ADJ) @(negedge clk);
    check("preload", {4'h0, digits()}, 20'h09959);
    adj_vld = 1'b0;
    repeat (DIV_RUN) @(negedge clk);
    check("pre_wrap", {4'h0, digits()}, 20'h09959);
    repeat (1) @(negedge clk);
    check("wrap_9959", {4'h0, digits()}, 20'h00000);

    // pause at 00:07
    repeat (7 * DIV_RUN) @(negedge clk);
    check("at_0007", {4'h0, digits()}, 20'h00007);
    pause_vld = 1'b1;
    repeat (500) @(negedge clk);
    check("pause_hold", {4'h0, digits()}, 20'h00007);
    check("pause_state", {18'd0, state}, 20'd1);
    pause_vld = 1'b0;
    repeat (9) @(negedge clk);
    check("resume_pre", {4'h0, digits()}, 20'h00007);
    repeat (1) @(negedge clk);
    check("resume_tick", {4'h0, digits()}, 20'h00008);

    // adjust seconds from 00:58, no carry into minutes
    repeat (50 * DIV_RUN) @(negedge clk);
    check("at_0058", {4'h0, digits()}, 20'h00058);
    adj_vld = 1'b1; adj_sel = 1'b1;
    repeat (9) @(negedge clk);
    check("adj_sec_wrap", {4'h0, digits()}, 20'h00000);
    check("adj_state", {18'd0, state}, 20'd2);
    repeat (12) @(negedge clk);
    check("adj_sec_3", {4'h0, digits()}, 20'h00003);
    adj_sel = 1'b0;
    repeat (20) @(negedge clk);
    check("adj_min_5", {4'h0, digits()}, 20'h00503);
    adj_sel = 1'b1;
    repeat (2) @(negedge clk);
    adj_sel = 1'b0;
    repeat (2) @(negedge clk);
    check("sel_mid_adj", {4'h0, digits()}, 20'h00603);

    // reach 12:34, then reset_vld on the run terminal count
    repeat (6 * DIV_ADJ) @(negedge clk);
    adj_sel = 1'b1;
    repeat (31 * DIV_ADJ) @(negedge clk);
    check("at_1234", {4'h0, digits()}, 20'h01234);
    adj_vld = 1'b0;
    repeat (DIV_RUN) @(negedge clk);
    check("pre_reset", {4'h0, digits()}, 20'h01234);
    reset_vld = 1'b1;
    @(negedge clk);
    reset_vld = 1'b0;
    check("reset_vld", {digits(), state, blank_sec, blank_min}, 20'h00000);

    // asynchronous reset while adjusting
    adj_vld = 1'b1; adj_sel = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_async", {4'h0, digits()}, 20'h00001);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {digits(), 2'b00, blank_sec, blank_min}, 20'h00000);
    @(negedge clk);
    adj_vld = 1'b0; adj_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_async_state", {18'd0, state}, 20'd0);

    // randomized soak across all modes
    hold = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        pause_vld = 1'($urandom_range(0, 1));
        adj_vld   = ($urandom_range(0, 2) == 0);
        adj_sel   = 1'($urandom_range(0, 1));
        hold      = $urandom_range(1, 40);
      end else begin
        hold--;
        if ($urandom_range(0, 15) == 0) adj_sel = ~adj_sel;
      end
      reset_vld = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    reset_vld = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
